// File: rtl/stacker_datapath.sv
// stacker_datapath: datapath responder for the block-stacker control FSM.
// Owns block position and bounce direction, the per-block pixel scan, the
// level-dependent move delay and the stop-key capture, and drives the VGA
// adapter write port directly.
//
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   reset_load             - sync active-low position/stop reinitialise
//   reset_counter          - sync active-low delay-counter clear
//   enable_counter         - advance delay counter
//   count_x_enable         - advance pixel scan
//   writeEn                - write strobe from FSM
//   colour_erase_enable    - drive black instead of COLOUR
//   ld_x, ld_y             - together, apply one position update
//   level                  - move-delay select (0: DELAY_L1, 1: DELAY_L2)
//   stop_key               - raw active-low push button (async)
//   done_plot              - last pixel of block presented this cycle
//   enable_erase           - move delay elapsed
//   stop_true              - stop request latched
//   vga_x/vga_y/vga_colour/vga_plot - VGA adapter write port
//   game_over              - stack reached top of screen (sticky)
module stacker_datapath #(
    parameter int unsigned BLOCK_W  = 16,
    parameter int unsigned BLOCK_H  = 4,
    parameter int unsigned STEP     = 4,
    parameter int unsigned Y_START  = 116,
    parameter logic [2:0]  COLOUR   = 3'b111,
    parameter int unsigned DELAY_L1 = 100000000,
    parameter int unsigned DELAY_L2 = 50000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       reset_load,
    input  logic       reset_counter,
    input  logic       enable_counter,
    input  logic       count_x_enable,
    input  logic       writeEn,
    input  logic       colour_erase_enable,
    input  logic       ld_x,
    input  logic       ld_y,
    input  logic       level,
    input  logic       stop_key,
    output logic       done_plot,
    output logic       enable_erase,
    output logic       stop_true,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       game_over
);

    localparam int unsigned XW    = 8;
    localparam int unsigned YW    = 7;
    localparam int unsigned CNTW  = 27;
    localparam int unsigned CXW   = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int unsigned CYW   = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;
    localparam int unsigned X_MAX = 160 - BLOCK_W;

    logic [XW-1:0]   x_pos_q, x_pos_d;
    logic [YW-1:0]   y_pos_q, y_pos_d;
    logic            dir_q, dir_d;
    logic            stop_lat_q, stop_lat_d;
    logic            game_over_q, game_over_d;
    logic [CXW-1:0]  cx_q, cx_d;
    logic [CYW-1:0]  cy_q, cy_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            sync3_q, sync3_d;

    logic            upd;
    logic            stop_fall;
    logic [CNTW-1:0] lim_m1;
    logic            last_x;
    logic            last_y;

    assign upd       = ld_x & ld_y;
    // sync3 holds the previous synchronised level for falling-edge detect
    assign stop_fall = sync3_q & ~sync2_q;
    assign lim_m1    = level ? CNTW'(DELAY_L2 - 1) : CNTW'(DELAY_L1 - 1);
    assign last_x    = (cx_q == CXW'(BLOCK_W - 1));
    assign last_y    = (cy_q == CYW'(BLOCK_H - 1));

    // Position, bounce direction, stop latch and game-over
    always_comb begin
        x_pos_d     = x_pos_q;
        y_pos_d     = y_pos_q;
        dir_d       = dir_q;
        stop_lat_d  = stop_lat_q;
        game_over_d = game_over_q;
        if (!reset_load) begin
            x_pos_d    = '0;
            y_pos_d    = YW'(Y_START);
            dir_d      = 1'b0;
            stop_lat_d = 1'b0;
        end else begin
            if (upd) begin
                if (stop_lat_q) begin
                    if (y_pos_q < YW'(BLOCK_H)) begin
                        game_over_d = 1'b1;
                    end else begin
                        y_pos_d = y_pos_q - YW'(BLOCK_H);
                    end
                    x_pos_d    = '0;
                    dir_d      = 1'b0;
                    stop_lat_d = 1'b0;
                end else if (!dir_q) begin
                    // widened compare so x_pos + STEP cannot wrap
                    if ((9'(x_pos_q) + 9'(STEP)) > 9'(X_MAX)) begin
                        dir_d   = 1'b1;
                        x_pos_d = x_pos_q - XW'(STEP);
                    end else begin
                        x_pos_d = x_pos_q + XW'(STEP);
                    end
                end else begin
                    if (x_pos_q < XW'(STEP)) begin
                        dir_d   = 1'b0;
                        x_pos_d = x_pos_q + XW'(STEP);
                    end else begin
                        x_pos_d = x_pos_q - XW'(STEP);
                    end
                end
            end
            // a fresh stop edge beats the clear from a same-cycle update
            if (stop_fall) begin
                stop_lat_d = 1'b1;
            end
        end
    end

    // Pixel scan over one block; held at pixel 0 while idle
    always_comb begin
        cx_d = '0;
        cy_d = '0;
        if (count_x_enable) begin
            cy_d = cy_q;
            if (last_x) begin
                cx_d = '0;
                cy_d = last_y ? '0 : (cy_q + CYW'(1));
            end else begin
                cx_d = cx_q + CXW'(1);
            end
        end
    end

    // Move-delay counter, saturating at the level-selected limit
    always_comb begin
        cnt_d = cnt_q;
        if (!reset_counter) begin
            cnt_d = '0;
        end else if (enable_counter) begin
            cnt_d = (cnt_q >= lim_m1) ? lim_m1 : (cnt_q + CNTW'(1));
        end
    end

    // Stop-key synchroniser chain
    always_comb begin
        sync1_d = stop_key;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_pos_q     <= '0;
            y_pos_q     <= YW'(Y_START);
            dir_q       <= 1'b0;
            stop_lat_q  <= 1'b0;
            game_over_q <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            cnt_q       <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync3_q     <= 1'b1;
        end else begin
            x_pos_q     <= x_pos_d;
            y_pos_q     <= y_pos_d;
            dir_q       <= dir_d;
            stop_lat_q  <= stop_lat_d;
            game_over_q <= game_over_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
        end
    end

    // Zero-latency outputs from registered state and current strobes
    assign vga_x        = x_pos_q + XW'(cx_q);
    assign vga_y        = y_pos_q + YW'(cy_q);
    assign vga_plot     = writeEn & count_x_enable;
    assign vga_colour   = colour_erase_enable ? 3'b000 : COLOUR;
    assign done_plot    = count_x_enable & last_x & last_y;
    assign enable_erase = (cnt_q == lim_m1);
    assign stop_true    = stop_lat_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_stacker_datapath.sv
// Directed self-checking bench for stacker_datapath (short move delays).
module tb_stacker_datapath;

    logic       clk = 1'b0;
    logic       resetn, reset_load, reset_counter, enable_counter;
    logic       count_x_enable, writeEn, colour_erase_enable;
    logic       ld_x, ld_y, level, stop_key;
    logic       done_plot, enable_erase, stop_true, vga_plot, game_over;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int tests = 0;
    int fails = 0;

    stacker_datapath #(.DELAY_L1(10), .DELAY_L2(5)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .reset_load          (reset_load),
        .reset_counter       (reset_counter),
        .enable_counter      (enable_counter),
        .count_x_enable      (count_x_enable),
        .writeEn             (writeEn),
        .colour_erase_enable (colour_erase_enable),
        .ld_x                (ld_x),
        .ld_y                (ld_y),
        .level               (level),
        .stop_key            (stop_key),
        .done_plot           (done_plot),
        .enable_erase        (enable_erase),
        .stop_true           (stop_true),
        .vga_x               (vga_x),
        .vga_y               (vga_y),
        .vga_colour          (vga_colour),
        .vga_plot            (vga_plot),
        .game_over           (game_over)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic test_reset;
        resetn = 1'b0; reset_load = 1'b1; reset_counter = 1'b1;
        enable_counter = 1'b0; count_x_enable = 1'b0; writeEn = 1'b0;
        colour_erase_enable = 1'b0; ld_x = 1'b0; ld_y = 1'b0;
        level = 1'b0; stop_key = 1'b1;
        repeat (2) tick();
        at_neg();
        tests++; if (vga_x !== 8'd0) begin fails++; $display("FAIL reset_vga_x got %0d exp 0", vga_x); end
        tests++; if (vga_y !== 7'd116) begin fails++; $display("FAIL reset_vga_y got %0d exp 116", vga_y); end
        tests++; if (vga_colour !== 3'b111) begin fails++; $display("FAIL reset_colour got %0d exp 7", vga_colour); end
        tests++; if (vga_plot !== 1'b0) begin fails++; $display("FAIL reset_plot got %b exp 0", vga_plot); end
        tests++; if (done_plot !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done_plot); end
        tests++; if (enable_erase !== 1'b0) begin fails++; $display("FAIL reset_erase got %b exp 0", enable_erase); end
        tests++; if (stop_true !== 1'b0) begin fails++; $display("FAIL reset_stop got %b exp 0", stop_true); end
        tests++; if (game_over !== 1'b0) begin fails++; $display("FAIL reset_game_over got %b exp 0", game_over); end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_scan;
        count_x_enable = 1'b1; writeEn = 1'b1;
        for (int i = 0; i < 64; i++) begin
            at_neg();
            tests++; if (vga_x !== 8'(i % 16)) begin fails++; $display("FAIL scan_x[%0d] got %0d exp %0d", i, vga_x, i % 16); end
            tests++; if (vga_y !== 7'(116 + i / 16)) begin fails++; $display("FAIL scan_y[%0d] got %0d exp %0d", i, vga_y, 116 + i / 16); end
            tests++; if (vga_plot !== 1'b1) begin fails++; $display("FAIL scan_plot[%0d] got %b exp 1", i, vga_plot); end
            tests++; if (done_plot !== (i == 63)) begin fails++; $display("FAIL scan_done[%0d] got %b exp %b", i, done_plot, i == 63); end
            tick();
        end
        // wrapped back to pixel 0; run partway then interrupt
        repeat (5) tick();
        at_neg();
        tests++; if (vga_x !== 8'd5) begin fails++; $display("FAIL midscan_x got %0d exp 5", vga_x); end
        count_x_enable = 1'b0;
        #1;
        tests++; if (vga_plot !== 1'b0) begin fails++; $display("FAIL idle_plot got %b exp 0", vga_plot); end
        tick();
        count_x_enable = 1'b1;
        at_neg();
        tests++; if (vga_x !== 8'd0 || vga_y !== 7'd116) begin fails++; $display("FAIL restart_xy got %0d,%0d exp 0,116", vga_x, vga_y); end
        count_x_enable = 1'b0; writeEn = 1'b0;
        tick();
    endtask

    task automatic test_delay;
        reset_counter = 1'b0;
        tick();
        reset_counter = 1'b1; enable_counter = 1'b1; level = 1'b0;
        for (int k = 0; k < 12; k++) begin
            at_neg();
            tests++; if (enable_erase !== (k >= 9)) begin fails++; $display("FAIL delay_l1[%0d] got %b exp %b", k, enable_erase, k >= 9); end
            tick();
        end
        reset_counter = 1'b0;
        tick();
        reset_counter = 1'b1; level = 1'b1;
        for (int k = 0; k < 7; k++) begin
            at_neg();
            tests++; if (enable_erase !== (k >= 4)) begin fails++; $display("FAIL delay_l2[%0d] got %b exp %b", k, enable_erase, k >= 4); end
            tick();
        end
        // count sits at 4: switching back to level 0 must drop the flag at once
        level = 1'b0;
        #1;
        tests++; if (enable_erase !== 1'b0) begin fails++; $display("FAIL delay_level_switch got %b exp 0", enable_erase); end
        enable_counter = 1'b0; reset_counter = 1'b0;
        tick();
        reset_counter = 1'b1;
        tick();
    endtask

    task automatic test_bounce;
        int exp_x;
        reset_load = 1'b0;
        tick();
        reset_load = 1'b1;
        ld_x = 1'b1;
        tick();
        ld_x = 1'b0;
        at_neg();
        tests++; if (vga_x !== 8'd0) begin fails++; $display("FAIL ld_x_alone got %0d exp 0", vga_x); end
        tick();
        for (int n = 1; n <= 73; n++) begin
            ld_x = 1'b1; ld_y = 1'b1;
            tick();
            ld_x = 1'b0; ld_y = 1'b0;
            if (n <= 36)      exp_x = 4 * n;
            else if (n <= 72) exp_x = 144 - 4 * (n - 36);
            else              exp_x = 4 * (n - 72);
            at_neg();
            tests++; if (vga_x !== 8'(exp_x)) begin fails++; $display("FAIL bounce[%0d] got %0d exp %0d", n, vga_x, exp_x); end
            tick();
        end
    endtask

    task automatic test_stop;
        stop_key = 1'b0;
        for (int k = 0; k < 5; k++) begin
            at_neg();
            tests++; if (stop_true !== (k >= 3)) begin fails++; $display("FAIL stop_latency[%0d] got %b exp %b", k, stop_true, k >= 3); end
            tick();
        end
        stop_key = 1'b1;
        repeat (4) tick();
        at_neg();
        tests++; if (stop_true !== 1'b1) begin fails++; $display("FAIL stop_hold got %b exp 1", stop_true); end
        tick();
        ld_x = 1'b1; ld_y = 1'b1;
        tick();
        ld_x = 1'b0; ld_y = 1'b0;
        at_neg();
        tests++; if (vga_y !== 7'd112 || vga_x !== 8'd0) begin fails++; $display("FAIL stack_xy got %0d,%0d exp 0,112", vga_x, vga_y); end
        tests++; if (stop_true !== 1'b0) begin fails++; $display("FAIL stack_stop_clear got %b exp 0", stop_true); end
        tick();
        stop_key = 1'b0;
        repeat (2) tick();
        stop_key = 1'b1;
        repeat (4) tick();
        // second press whose edge lands on the update edge
        stop_key = 1'b0;
        repeat (2) tick();
        ld_x = 1'b1; ld_y = 1'b1;
        tick();
        ld_x = 1'b0; ld_y = 1'b0; stop_key = 1'b1;
        at_neg();
        tests++; if (stop_true !== 1'b1) begin fails++; $display("FAIL stop_vs_update got %b exp 1", stop_true); end
        tests++; if (vga_y !== 7'd108) begin fails++; $display("FAIL stop_vs_update_y got %0d exp 108", vga_y); end
        repeat (4) tick();
        ld_x = 1'b1; ld_y = 1'b1;
        tick();
        ld_x = 1'b0; ld_y = 1'b0;
        at_neg();
        tests++; if (vga_y !== 7'd104 || stop_true !== 1'b0) begin fails++; $display("FAIL stack2 got y=%0d stop=%b exp 104,0", vga_y, stop_true); end
        tick();
    endtask

    task automatic test_game_over;
        for (int i = 1; i <= 27; i++) begin
            stop_key = 1'b0;
            repeat (2) tick();
            stop_key = 1'b1;
            repeat (3) tick();
            ld_x = 1'b1; ld_y = 1'b1;
            tick();
            ld_x = 1'b0; ld_y = 1'b0;
            at_neg();
            if (i <= 26) begin
                tests++; if (vga_y !== 7'(104 - 4 * i) || game_over !== 1'b0) begin fails++; $display("FAIL descend[%0d] got y=%0d go=%b exp %0d,0", i, vga_y, game_over, 104 - 4 * i); end
            end else begin
                tests++; if (game_over !== 1'b1) begin fails++; $display("FAIL game_over got %b exp 1", game_over); end
                tests++; if (vga_y !== 7'd0 || vga_x !== 8'd0) begin fails++; $display("FAIL game_over_xy got %0d,%0d exp 0,0", vga_x, vga_y); end
            end
            tick();
        end
        reset_load = 1'b0;
        tick();
        reset_load = 1'b1;
        at_neg();
        tests++; if (game_over !== 1'b1) begin fails++; $display("FAIL game_over_sticky got %b exp 1", game_over); end
        tests++; if (vga_y !== 7'd116) begin fails++; $display("FAIL reload_y got %0d exp 116", vga_y); end
        tick();
    endtask

    task automatic test_mid_reset;
        level = 1'b1; enable_counter = 1'b1; count_x_enable = 1'b1; writeEn = 1'b1;
        repeat (10) tick();
        at_neg();
        tests++; if (enable_erase !== 1'b1 || vga_x !== 8'd10) begin fails++; $display("FAIL pre_reset got erase=%b x=%0d exp 1,10", enable_erase, vga_x); end
        #2;
        resetn = 1'b0;
        #1;
        tests++; if (vga_x !== 8'd0 || vga_y !== 7'd116) begin fails++; $display("FAIL async_xy got %0d,%0d exp 0,116", vga_x, vga_y); end
        tests++; if (enable_erase !== 1'b0 || done_plot !== 1'b0) begin fails++; $display("FAIL async_erase_done got %b,%b exp 0,0", enable_erase, done_plot); end
        tests++; if (game_over !== 1'b0 || stop_true !== 1'b0) begin fails++; $display("FAIL async_go_stop got %b,%b exp 0,0", game_over, stop_true); end
        count_x_enable = 1'b0; writeEn = 1'b0; enable_counter = 1'b0; level = 1'b0;
        #1;
        tests++; if (vga_plot !== 1'b0 || vga_colour !== 3'b111) begin fails++; $display("FAIL async_plot_colour got %b,%0d exp 0,7", vga_plot, vga_colour); end
        tick();
        resetn = 1'b1;
        tick();
        colour_erase_enable = 1'b1; count_x_enable = 1'b1; writeEn = 1'b1;
        for (int i = 0; i < 64; i++) begin
            at_neg();
            tests++; if (vga_colour !== 3'b000 || vga_plot !== 1'b1) begin fails++; $display("FAIL erase[%0d] got colour=%0d plot=%b exp 0,1", i, vga_colour, vga_plot); end
            tests++; if (done_plot !== (i == 63)) begin fails++; $display("FAIL erase_done[%0d] got %b exp %b", i, done_plot, i == 63); end
            tick();
        end
        colour_erase_enable = 1'b0; count_x_enable = 1'b0; writeEn = 1'b0;
        #1;
        tests++; if (vga_colour !== 3'b111) begin fails++; $display("FAIL colour_restore got %0d exp 7", vga_colour); end
        tick();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_delay();
        test_bounce();
        test_stop();
        test_game_over();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d tests", tests);
        $fatal(1, "timeout");
    end

endmodule
